dpd_coeff_bank: RTL and testbench



---
 rtl/dpd_coeff_bank.sv | 148 ++++++++++++++
 tb/tb_dpd_coeff_bank.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpd_coeff_bank.sv
// Shadow/active coefficient bank for the odd-order DPD actuator.
// Shadow writes go in while idle; a committed swap is taken on frame_sync, then a guard window runs.
module dpd_coeff_bank #(
    parameter int INT_WIDTH   = 6,
    parameter int FRACT_WIDTH = 12,
    parameter int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH,
    parameter int GUARD       = 6
) (
    input  logic                         clk_368,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [2:0]                   wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         commit,
    input  logic                         abort,
    input  logic                         frame_sync,
    input  logic                         bypass,
    output logic signed [DATA_WIDTH-1:0] a10_r,
    output logic signed [DATA_WIDTH-1:0] a10_i,
    output logic signed [DATA_WIDTH-1:0] a30_r,
    output logic signed [DATA_WIDTH-1:0] a30_i,
    output logic signed [DATA_WIDTH-1:0] a50_r,
    output logic signed [DATA_WIDTH-1:0] a50_i,
    output logic                         pending,
    output logic                         commit_done,
    output logic                         err_addr,
    output logic [7:0]                   swap_cnt
);

    localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRACT_WIDTH);

    typedef enum logic [1:0] {IDLE, PENDING, HOLD} state_t;

    // Identity actuator: unity linear term, all higher orders zero.
    function automatic logic signed [DATA_WIDTH-1:0] identity_coeff(input int idx);
        return (idx == 0) ? ONE : '0;
    endfunction

    state_t                        state_q;
    logic [7:0]                    guard_q;
    logic                          pending_q;
    logic                          commit_done_q;
    logic                          err_addr_q;
    logic [7:0]                    swap_cnt_q;

    logic signed [DATA_WIDTH-1:0]  shadow_q [6];
    logic signed [DATA_WIDTH-1:0]  shadow_d [6];
    logic signed [DATA_WIDTH-1:0]  act_q    [6];
    logic signed [DATA_WIDTH-1:0]  act_d    [6];
    logic signed [DATA_WIDTH-1:0]  out_q    [6];
    logic signed [DATA_WIDTH-1:0]  out_d    [6];

    logic                          wr_accept;
    logic                          swap_go;

    assign wr_ready  = (state_q == IDLE);
    assign wr_accept = wr_valid && wr_ready;
    assign swap_go   = (state_q == PENDING) && frame_sync && !abort;

    // Output regs take the next active value so a swap is visible right after the sync edge.
    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        for (int i = 0; i < 6; i++) begin
            if (wr_accept && (wr_addr == 3'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
        if (swap_go) begin
            act_d = shadow_q;
        end
        for (int i = 0; i < 6; i++) begin
            out_d[i] = bypass ? identity_coeff(i) : act_d[i];
        end
    end

    always_ff @(posedge clk_368 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= identity_coeff(i);
                act_q[i]    <= identity_coeff(i);
                out_q[i]    <= identity_coeff(i);
            end
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            out_q    <= out_d;
        end
    end

    always_ff @(posedge clk_368 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            guard_q       <= '0;
            pending_q     <= 1'b0;
            commit_done_q <= 1'b0;
            err_addr_q    <= 1'b0;
            swap_cnt_q    <= '0;
        end else begin
            commit_done_q <= 1'b0;
            err_addr_q    <= wr_accept && (wr_addr > 3'd5);
            case (state_q)
                IDLE: begin
                    if (commit) begin
                        state_q   <= PENDING;
                        pending_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end else if (frame_sync) begin
                        state_q       <= HOLD;
                        pending_q     <= 1'b0;
                        guard_q       <= 8'(GUARD - 1);
                        commit_done_q <= 1'b1;
                        swap_cnt_q    <= swap_cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (guard_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        guard_q <= guard_q - 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign a10_r       = out_q[0];
    assign a10_i       = out_q[1];
    assign a30_r       = out_q[2];
    assign a30_i       = out_q[3];
    assign a50_r       = out_q[4];
    assign a50_i       = out_q[5];
    assign pending     = pending_q;
    assign commit_done = commit_done_q;
    assign err_addr    = err_addr_q;
    assign swap_cnt    = swap_cnt_q;

endmodule

// File: tb/tb_dpd_coeff_bank.sv
// Bench for dpd_coeff_bank: per-cycle vector table through a scoreboard queue, then wrap and reset corners.
`timescale 1ns/1ps
module tb_dpd_coeff_bank;

    localparam int DW    = 18;
    localparam int GUARD = 6;

    typedef logic [5:0][DW-1:0] coefs_t;

    typedef struct {
        logic          wv;
        logic [2:0]    wa;
        logic [DW-1:0] wd;
        logic          cm;
        logic          ab;
        logic          fs;
        logic          bp;
        coefs_t        c;
        logic          pd;
        logic          dn;
        logic          er;
        logic          rd;
        logic [7:0]    cn;
    } vec_t;

    logic          clk_368 = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          commit;
    logic          abort;
    logic          frame_sync;
    logic          bypass;
    logic [DW-1:0] a10_r, a10_i, a30_r, a30_i, a50_r, a50_i;
    logic          pending;
    logic          commit_done;
    logic          err_addr;
    logic [7:0]    swap_cnt;

    int     total = 0;
    int     bad   = 0;
    vec_t   vecs  [$];
    vec_t   exp_q [$];
    coefs_t R, S1, S2, S3;
    string  cname [6] = '{"a10_r", "a10_i", "a30_r", "a30_i", "a50_r", "a50_i"};

    dpd_coeff_bank #(
        .INT_WIDTH  (6),
        .FRACT_WIDTH(12),
        .GUARD      (GUARD)
    ) dut (
        .clk_368    (clk_368),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .abort      (abort),
        .frame_sync (frame_sync),
        .bypass     (bypass),
        .a10_r      (a10_r),
        .a10_i      (a10_i),
        .a30_r      (a30_r),
        .a30_i      (a30_i),
        .a50_r      (a50_r),
        .a50_i      (a50_i),
        .pending    (pending),
        .commit_done(commit_done),
        .err_addr   (err_addr),
        .swap_cnt   (swap_cnt)
    );

    always #5 clk_368 = ~clk_368;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic coefs_t cur();
        return {a50_i, a50_r, a30_i, a30_r, a10_i, a10_r};
    endfunction

    task automatic add(input int wv, input int wa, input int wd, input int cm, input int ab,
                       input int fs, input int bp, input coefs_t c, input int pd, input int dn,
                       input int er, input int rd, input int cn);
        vec_t v;
        v.wv = 1'(wv); v.wa = 3'(wa); v.wd = DW'(wd);
        v.cm = 1'(cm); v.ab = 1'(ab); v.fs = 1'(fs); v.bp = 1'(bp);
        v.c  = c;
        v.pd = 1'(pd); v.dn = 1'(dn); v.er = 1'(er); v.rd = 1'(rd); v.cn = 8'(cn);
        vecs.push_back(v);
    endtask

    task automatic hold(input int n, input coefs_t c, input int cn);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, c, 0, 0, 0, 0, cn);
    endtask

    task automatic drive(input vec_t v);
        wr_valid   = v.wv;
        wr_addr    = v.wa;
        wr_data    = v.wd;
        commit     = v.cm;
        abort      = v.ab;
        frame_sync = v.fs;
        bypass     = v.bp;
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        coefs_t a = cur();
        for (int k = 0; k < 6; k++)
            chk($sformatf("%s.%s", tag, cname[k]), 32'(a[k]), 32'(e.c[k]));
        chk({tag, ".pending"},     32'(pending),     32'(e.pd));
        chk({tag, ".commit_done"}, 32'(commit_done), 32'(e.dn));
        chk({tag, ".err_addr"},    32'(err_addr),    32'(e.er));
        chk({tag, ".wr_ready"},    32'(wr_ready),    32'(e.rd));
        chk({tag, ".swap_cnt"},    32'(swap_cnt),    32'(e.cn));
    endtask

    initial begin
        vec_t e;
        int   exp_cnt;

        R  = '0;  R[0]  = DW'(4096);
        S1 = R;   S1[2] = DW'('h00800); S1[5] = DW'('h3F000);
        S2 = S1;  S2[0] = DW'('h00C00);
        S3 = S2;  S3[1] = DW'('h00055);

        rst_n = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; abort = 1'b0; frame_sync = 1'b0; bypass = 1'b0;
        repeat (2) @(posedge clk_368);
        #1;
        e.c = R; e.pd = 1'b0; e.dn = 1'b0; e.er = 1'b0; e.rd = 1'b1; e.cn = 8'd0;
        check_vec("reset", e);
        @(negedge clk_368);
        rst_n = 1'b1;

        // wv wa  wd        cm ab fs bp  coefs pd dn er rd cnt
        add(1, 2, 'h00800,  0, 0, 0, 0,  R,    0, 0, 0, 1, 0);
        add(1, 5, 'h3F000,  1, 0, 0, 0,  R,    1, 0, 0, 0, 0);
        add(0, 0, 0,        0, 0, 0, 0,  R,    1, 0, 0, 0, 0);
        add(0, 0, 0,        0, 0, 0, 0,  R,    1, 0, 0, 0, 0);
        add(0, 0, 0,        0, 0, 1, 0,  S1,   0, 1, 0, 0, 1);
        add(0, 0, 0,        0, 0, 0, 0,  S1,   0, 0, 0, 0, 1);
        add(0, 0, 0,        1, 1, 1, 0,  S1,   0, 0, 0, 0, 1);
        add(1, 0, 'h00123,  0, 0, 0, 0,  S1,   0, 0, 0, 0, 1);
        hold(2, S1, 1);
        add(0, 0, 0,        0, 0, 0, 0,  S1,   0, 0, 0, 1, 1);
        add(0, 0, 0,        1, 0, 0, 0,  S1,   1, 0, 0, 0, 1);
        add(0, 0, 0,        0, 1, 1, 0,  S1,   0, 0, 0, 1, 1);
        add(0, 0, 0,        0, 0, 1, 0,  S1,   0, 0, 0, 1, 1);
        add(0, 0, 0,        1, 0, 1, 0,  S1,   1, 0, 0, 0, 1);
        add(0, 0, 0,        0, 0, 1, 0,  S1,   0, 1, 0, 0, 2);
        hold(5, S1, 2);
        add(0, 0, 0,        0, 0, 0, 0,  S1,   0, 0, 0, 1, 2);
        add(1, 7, 'h1FFFF,  0, 0, 0, 0,  S1,   0, 0, 1, 1, 2);
        add(0, 0, 0,        0, 0, 0, 0,  S1,   0, 0, 0, 1, 2);
        add(0, 0, 0,        1, 0, 0, 0,  S1,   1, 0, 0, 0, 2);
        add(0, 0, 0,        0, 0, 1, 0,  S1,   0, 1, 0, 0, 3);
        hold(5, S1, 3);
        add(0, 0, 0,        0, 0, 0, 0,  S1,   0, 0, 0, 1, 3);
        add(1, 0, 'h00C00,  1, 0, 0, 0,  S1,   1, 0, 0, 0, 3);
        add(0, 0, 0,        0, 0, 1, 0,  S2,   0, 1, 0, 0, 4);
        add(0, 0, 0,        0, 0, 0, 1,  R,    0, 0, 0, 0, 4);
        add(0, 0, 0,        0, 0, 0, 1,  R,    0, 0, 0, 0, 4);
        add(0, 0, 0,        0, 0, 0, 0,  S2,   0, 0, 0, 0, 4);
        hold(2, S2, 4);
        add(0, 0, 0,        0, 0, 0, 0,  S2,   0, 0, 0, 1, 4);
        add(1, 1, 'h00055,  1, 0, 0, 1,  R,    1, 0, 0, 0, 4);
        add(0, 0, 0,        0, 0, 1, 1,  R,    0, 1, 0, 0, 5);
        add(0, 0, 0,        0, 0, 0, 0,  S3,   0, 0, 0, 0, 5);
        hold(4, S3, 5);
        add(0, 0, 0,        0, 0, 0, 0,  S3,   0, 0, 0, 1, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_368);
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(posedge clk_368);
            #1;
            e = exp_q.pop_front();
            check_vec($sformatf("v%0d", i), e);
        end

        // Swap counter wrap: 251 more swaps bring the count from 5 to 0.
        exp_cnt = 5;
        for (int k = 0; k < 251; k++) begin
            @(negedge clk_368);
            commit = 1'b1;
            @(negedge clk_368);
            commit = 1'b0;
            frame_sync = 1'b1;
            @(posedge clk_368);
            #1;
            exp_cnt = (exp_cnt + 1) % 256;
            chk($sformatf("wrap%0d.swap_cnt", k), 32'(swap_cnt), 32'(exp_cnt));
            chk($sformatf("wrap%0d.commit_done", k), 32'(commit_done), 32'd1);
            @(negedge clk_368);
            frame_sync = 1'b0;
            repeat (GUARD) @(posedge clk_368);
            #1;
            chk($sformatf("wrap%0d.wr_ready", k), 32'(wr_ready), 32'd1);
        end
        chk("wrap.final_cnt", 32'(swap_cnt), 32'd0);
        chk("wrap.a10_i", 32'(a10_i), 32'h55);

        // Reset asserted while in HOLD.
        @(negedge clk_368);
        commit = 1'b1;
        @(negedge clk_368);
        commit = 1'b0;
        frame_sync = 1'b1;
        @(posedge clk_368);
        #1;
        chk("rh.pre_cnt", 32'(swap_cnt), 32'd1);
        chk("rh.pre_a10_r", 32'(a10_r), 32'h00C00);
        @(negedge clk_368);
        frame_sync = 1'b0;
        @(posedge clk_368);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rh.a10_r", 32'(a10_r), 32'd4096);
        chk("rh.a10_i", 32'(a10_i), 32'd0);
        chk("rh.a30_r", 32'(a30_r), 32'd0);
        chk("rh.a50_i", 32'(a50_i), 32'd0);
        chk("rh.swap_cnt", 32'(swap_cnt), 32'd0);
        chk("rh.wr_ready", 32'(wr_ready), 32'd1);
        chk("rh.pending", 32'(pending), 32'd0);
        chk("rh.commit_done", 32'(commit_done), 32'd0);

        // Shadow must also be back at identity after reset.
        @(negedge clk_368);
        rst_n = 1'b1;
        @(negedge clk_368);
        commit = 1'b1;
        @(negedge clk_368);
        commit = 1'b0;
        frame_sync = 1'b1;
        @(posedge clk_368);
        #1;
        chk("post.a10_r", 32'(a10_r), 32'd4096);
        chk("post.a10_i", 32'(a10_i), 32'd0);
        chk("post.a30_r", 32'(a30_r), 32'd0);
        chk("post.a50_i", 32'(a50_i), 32'd0);
        chk("post.swap_cnt", 32'(swap_cnt), 32'd1);
        chk("post.commit_done", 32'(commit_done), 32'd1);
        @(negedge clk_368);
        frame_sync = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
